// File: rtl/shift_pkg.sv
// Shared constants for the bit serializer/deserializer family.
// State and direction encodings plus the bit-counter width helper.
package shift_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

  // Bits needed to count 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Bit position counter with clear, enable and terminal-count flag.
// Ports: clk, rst, clr, en, cnt[W-1:0], term (cnt == TERM).
module shift_bit_counter #(
  parameter int W    = 3,
  parameter int TERM = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == W'(TERM));

endmodule

// File: rtl/shift_serializer_ctrl.sv
// Parallel-to-serial transmit stage: n-bit words in over valid/ready,
// bits out MSB- or LSB-first with a last-bit marker and backpressure.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_data/msb_first,
//        sout/sout_valid/sout_ready/sout_last, busy.
// Option: define SHIFT_SERIALIZER_PARITY_EN to append an even-parity bit.
module shift_serializer_ctrl
  import shift_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_data,
  input  logic         msb_first,
  output logic         sout,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic         sout_last,
  output logic         busy
);

`ifdef SHIFT_SERIALIZER_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif

  localparam int CW   = cnt_width(n) + PW;
  localparam int LAST = n - 1 + PW;

  logic [0:0]    state;
  logic [n-1:0]  sreg;
  logic          dir;
  logic [CW-1:0] cnt;
  logic          term;
  logic          par_bit;
  logic          act;
  logic          hs;
  logic          fire;
  logic          data_bit;

  assign act  = !rst && (state == ST_SHIFT);
  assign hs   = in_valid && in_ready;
  assign fire = act && sout_ready;

  shift_bit_counter #(
    .W    (CW),
    .TERM (LAST)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (hs || (fire && term)),
    .en   (fire && !term),
    .cnt  (cnt),
    .term (term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sreg  <= '0;
      dir   <= DIR_LSB;
    end else if (hs) begin
      state <= ST_SHIFT;
      sreg  <= in_data;
      dir   <= msb_first;
    end else if (fire && term) begin
      state <= ST_IDLE;
      sreg  <= '0;
    end else if (fire) begin
      sreg <= (dir == DIR_MSB) ? {sreg[n-2:0], 1'b0}
                               : {1'b0, sreg[n-1:1]};
    end
  end

`ifdef SHIFT_SERIALIZER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (hs) begin
      par_bit <= ^in_data;
    end
  end
`else
  assign par_bit = 1'b0;
`endif

  assign data_bit = (dir == DIR_MSB) ? sreg[n-1] : sreg[0];

  // Positions at or beyond n only exist when the parity bit is enabled.
  assign in_ready   = !rst && (state == ST_IDLE);
  assign sout_valid = act;
  assign busy       = act;
  assign sout       = act && ((cnt < CW'(n)) ? data_bit : par_bit);
  assign sout_last  = act && term;

endmodule
